// File: rtl/fsmc_pkg.sv
// Shared types and helpers for the FSMC bus scheduler: FSM state encoding,
// default error read pattern and the module-select decoder.
package fsmc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        ADDR_HOLD,
        WR_REQ
    } state_t;

    localparam logic [15:0] ERR_PATTERN_DEFAULT = 16'hDEAD;

    // Widest cs vector the decoder accepts; narrower selects are zero-extended.
    localparam int MAX_MODULES = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } sel_decode_t;

    // valid is set only when exactly one bit is high; idx is that bit's position.
    function automatic sel_decode_t onehot_to_idx(input logic [MAX_MODULES-1:0] vec);
        sel_decode_t result;
        int unsigned ones;
        result = '0;
        ones   = 0;
        for (int i = 0; i < MAX_MODULES; i++) begin
            if (vec[i]) begin
                result.idx = 5'(i);
                ones++;
            end
        end
        result.valid = (ones == 1);
        return result;
    endfunction

endpackage

// File: rtl/fsmc_req_timer.sv
// Request timeout counter: cleared when a request starts, counts cycles
// without acknowledge, and pulses expire on the last allowed cycle.
module fsmc_req_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign expire = enable && (count == W'(CYCLES - 1));

endmodule

// File: rtl/fsmc_bus_scheduler.sv
// Converts FSMC address/data phases into req/ack transactions on one of
// NUM_MODULES user modules, prefetching read data on every address phase.
module fsmc_bus_scheduler
    import fsmc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_MODULES    = 4,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] ERR_PATTERN = DATA_WIDTH'(ERR_PATTERN_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MODULES-1:0] cs,
    input  logic                   addr_en,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  bus_data,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic [SEL_WIDTH-1:0]   m_sel,
    output logic [DATA_WIDTH-1:0]  m_addr,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic                   m_rd_req,
    output logic                   m_wr_req,
    input  logic [NUM_MODULES-1:0] m_ack,
    input  logic [DATA_WIDTH-1:0]  m_rdata [NUM_MODULES],
    output logic                   busy,
    output logic [7:0]             timeout_cnt,
    output logic [7:0]             decode_err_cnt
);

    state_t         state, state_n;
    sel_decode_t    dec;
    logic [SEL_WIDTH-1:0] sel_idx;
    logic           ack_sel;
    logic           wr_pending;
    logic           wr_en_prev;
    logic           timer_clear, timer_en, expire;
    logic           load_addr, load_wdata, set_pending, clr_pending;
    logic           load_resp_ack, load_resp_err, inc_timeout, inc_decode_err;

    assign dec     = onehot_to_idx(MAX_MODULES'(cs));
    assign sel_idx = SEL_WIDTH'(dec.idx);
    assign ack_sel = m_ack[m_sel];

    assign timer_en    = ((state == RD_REQ) || (state == WR_REQ)) && !ack_sel && !addr_en;
    assign timer_clear = addr_en || (state_n != state);

    fsmc_req_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        load_addr      = 1'b0;
        load_wdata     = 1'b0;
        set_pending    = 1'b0;
        clr_pending    = 1'b0;
        load_resp_ack  = 1'b0;
        load_resp_err  = 1'b0;
        inc_timeout    = 1'b0;
        inc_decode_err = 1'b0;

        // A new address phase wins over anything in flight, including a same-cycle ack.
        if (addr_en) begin
            clr_pending = 1'b1;
            if (dec.valid) begin
                load_addr = 1'b1;
                state_n   = RD_REQ;
            end else begin
                inc_decode_err = 1'b1;
                state_n        = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                RD_REQ: begin
                    if (rd_en) begin
                        load_wdata  = 1'b1;
                        set_pending = 1'b1;
                    end
                    if (ack_sel || expire) begin
                        load_resp_ack = ack_sel;
                        load_resp_err = !ack_sel;
                        inc_timeout   = !ack_sel;
                        state_n       = (wr_pending || rd_en) ? WR_REQ : ADDR_HOLD;
                    end
                end
                ADDR_HOLD: begin
                    if (rd_en) begin
                        load_wdata = 1'b1;
                        state_n    = WR_REQ;
                    end else if (wr_en_prev && !wr_en) begin
                        state_n = IDLE;
                    end
                end
                WR_REQ: begin
                    if (ack_sel || expire) begin
                        inc_timeout = !ack_sel;
                        clr_pending = 1'b1;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_addr         <= '0;
            m_sel          <= '0;
            m_wdata        <= '0;
            resp_data      <= '0;
            wr_pending     <= 1'b0;
            wr_en_prev     <= 1'b0;
            timeout_cnt    <= '0;
            decode_err_cnt <= '0;
        end else begin
            wr_en_prev <= wr_en;
            if (load_addr) begin
                m_addr <= bus_data;
                m_sel  <= sel_idx;
            end
            if (load_wdata) begin
                m_wdata <= bus_data;
            end
            if (clr_pending) begin
                wr_pending <= 1'b0;
            end else if (set_pending) begin
                wr_pending <= 1'b1;
            end
            if (load_resp_ack) begin
                resp_data <= m_rdata[m_sel];
            end else if (load_resp_err) begin
                resp_data <= ERR_PATTERN;
            end
            if (inc_timeout && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            if (inc_decode_err && (decode_err_cnt != 8'hFF)) begin
                decode_err_cnt <= decode_err_cnt + 8'd1;
            end
        end
    end

    assign m_rd_req = (state == RD_REQ);
    assign m_wr_req = (state == WR_REQ);
    assign busy     = (state != IDLE);

endmodule
